// File: rtl/packet_receiver_fsm.sv
// Packet receiver: validates a NO_ACK/ACK header, gathers the peer public key and commits it atomically.
// Optional build macro PK_STABLE_CHECK_EN: pk_valid requires two consecutive accepted packets with identical keys.
module packet_receiver_fsm #(
  parameter int WIDTH           = 16,
  parameter int PUBLIC_KEY_SIZE = 256,
  parameter int LOGSIZE         = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       incoming_packet_new,
  output logic [LOGSIZE-1:0]         incoming_packet_read_index,
  input  logic [WIDTH-1:0]           incoming_packet_read_data,
  output logic [PUBLIC_KEY_SIZE-1:0] their_pk,
  output logic                       pk_valid,
  output logic                       peer_ack,
  output logic                       bad_packet,
  output logic                       dropped_packet,
  output logic                       busy
);

  localparam int                 NUM_WORDS  = PUBLIC_KEY_SIZE / WIDTH;
  localparam logic [LOGSIZE-1:0] LAST_IDX   = LOGSIZE'(NUM_WORDS);
  localparam logic [WIDTH-1:0]   HDR_NO_ACK = WIDTH'(16'h5555);
  localparam logic [WIDTH-1:0]   HDR_ACK    = WIDTH'(16'hAAAA);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR_WAIT  = 3'd1,
    HDR_CHECK = 3'd2,
    KEY_READ  = 3'd3,
    COMMIT    = 3'd4
  } state_t;

  state_t                     state_r, state_s;
  logic [LOGSIZE-1:0]         read_index_r, read_index_s;
  logic [LOGSIZE-1:0]         word_cnt_r, word_cnt_s;
  logic [PUBLIC_KEY_SIZE-1:0] staging_r, staging_s;
  logic                       staging_ack_r, staging_ack_s;
  logic [PUBLIC_KEY_SIZE-1:0] their_pk_r, their_pk_s;
  logic                       pk_valid_r, pk_valid_s;
  logic                       peer_ack_r, peer_ack_s;
  logic                       bad_r, bad_s;
  logic                       dropped_r, dropped_s;
  logic                       busy_r, busy_s;
`ifdef PK_STABLE_CHECK_EN
  logic                       cand_r, cand_s;
`endif

  // Next-state, datapath and output-pulse decode
  always_comb begin
    state_s       = state_r;
    read_index_s  = read_index_r;
    word_cnt_s    = word_cnt_r;
    staging_s     = staging_r;
    staging_ack_s = staging_ack_r;
    their_pk_s    = their_pk_r;
    pk_valid_s    = pk_valid_r;
    peer_ack_s    = peer_ack_r;
    bad_s         = 1'b0;
`ifdef PK_STABLE_CHECK_EN
    cand_s        = cand_r;
`endif
    // A new packet is only taken from IDLE; COMMIT still counts as busy.
    dropped_s     = incoming_packet_new && (state_r != IDLE);

    case (state_r)
      IDLE: begin
        if (incoming_packet_new) begin
          read_index_s = {LOGSIZE{1'b0}};
          state_s      = HDR_WAIT;
        end else begin
          state_s      = IDLE;
        end
      end
      HDR_WAIT: begin
        read_index_s = LOGSIZE'(1);
        state_s      = HDR_CHECK;
      end
      HDR_CHECK: begin
        if ((incoming_packet_read_data == HDR_NO_ACK) || (incoming_packet_read_data == HDR_ACK)) begin
          staging_ack_s = (incoming_packet_read_data == HDR_ACK);
          read_index_s  = read_index_r + LOGSIZE'(1);
          word_cnt_s    = LOGSIZE'(1);
          state_s       = KEY_READ;
        end else begin
          bad_s   = 1'b1;
          state_s = IDLE;
        end
      end
      KEY_READ: begin
        // Shifting in MSB-first leaves word k at slot k once all words are in.
        staging_s = {staging_r[PUBLIC_KEY_SIZE-WIDTH-1:0], incoming_packet_read_data};
        if (read_index_r != LAST_IDX) begin
          read_index_s = read_index_r + LOGSIZE'(1);
        end else begin
          read_index_s = read_index_r;
        end
        if (word_cnt_r == LAST_IDX) begin
          state_s = COMMIT;
        end else begin
          word_cnt_s = word_cnt_r + LOGSIZE'(1);
          state_s    = KEY_READ;
        end
      end
      COMMIT: begin
        their_pk_s = staging_r;
        peer_ack_s = staging_ack_r;
`ifdef PK_STABLE_CHECK_EN
        if (cand_r && (their_pk_r == staging_r)) begin
          pk_valid_s = 1'b1;
        end else begin
          pk_valid_s = 1'b0;
        end
        cand_s     = 1'b1;
`else
        pk_valid_s = 1'b1;
`endif
        state_s    = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      read_index_r  <= {LOGSIZE{1'b0}};
      word_cnt_r    <= {LOGSIZE{1'b0}};
      staging_r     <= {PUBLIC_KEY_SIZE{1'b0}};
      staging_ack_r <= 1'b0;
      their_pk_r    <= {PUBLIC_KEY_SIZE{1'b0}};
      pk_valid_r    <= 1'b0;
      peer_ack_r    <= 1'b0;
      bad_r         <= 1'b0;
      dropped_r     <= 1'b0;
      busy_r        <= 1'b0;
`ifdef PK_STABLE_CHECK_EN
      cand_r        <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      read_index_r  <= read_index_s;
      word_cnt_r    <= word_cnt_s;
      staging_r     <= staging_s;
      staging_ack_r <= staging_ack_s;
      their_pk_r    <= their_pk_s;
      pk_valid_r    <= pk_valid_s;
      peer_ack_r    <= peer_ack_s;
      bad_r         <= bad_s;
      dropped_r     <= dropped_s;
      busy_r        <= busy_s;
`ifdef PK_STABLE_CHECK_EN
      cand_r        <= cand_s;
`endif
    end
  end

  assign incoming_packet_read_index = read_index_r;
  assign their_pk                   = their_pk_r;
  assign pk_valid                   = pk_valid_r;
  assign peer_ack                   = peer_ack_r;
  assign bad_packet                 = bad_r;
  assign dropped_packet             = dropped_r;
  assign busy                       = busy_r;

endmodule

// File: tb/tb_packet_receiver_fsm.sv
// Directed bench for packet_receiver_fsm: models the packet buffer as a one-cycle-latency RAM.
module tb_packet_receiver_fsm;

  logic         clock = 1'b0;
  logic         reset;
  logic         incoming_packet_new;
  logic [4:0]   incoming_packet_read_index;
  logic [15:0]  incoming_packet_read_data;
  logic [255:0] their_pk;
  logic         pk_valid;
  logic         peer_ack;
  logic         bad_packet;
  logic         dropped_packet;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:31];

`ifdef PK_STABLE_CHECK_EN
  localparam logic EXP_FIRST = 1'b0;
  localparam logic EXP_DIFF  = 1'b0;
`else
  localparam logic EXP_FIRST = 1'b1;
  localparam logic EXP_DIFF  = 1'b1;
`endif

  packet_receiver_fsm dut (
    .clock                      (clock),
    .reset                      (reset),
    .incoming_packet_new        (incoming_packet_new),
    .incoming_packet_read_index (incoming_packet_read_index),
    .incoming_packet_read_data  (incoming_packet_read_data),
    .their_pk                   (their_pk),
    .pk_valid                   (pk_valid),
    .peer_ack                   (peer_ack),
    .bad_packet                 (bad_packet),
    .dropped_packet             (dropped_packet),
    .busy                       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) incoming_packet_read_data <= mem[incoming_packet_read_index];

  function automatic logic [255:0] exp_key(input logic [15:0] base);
    logic [255:0] k;
    k = '0;
    for (int i = 1; i <= 16; i++) k[256 - i*16 +: 16] = base + 16'(i);
    return k;
  endfunction

  task automatic load_pkt(input logic [15:0] hdr, input logic [15:0] base);
    mem[0] = hdr;
    for (int i = 1; i <= 16; i++) mem[i] = base + 16'(i);
  endtask

  // Drives one pulse; returns at the falling edge right after the sampling edge E0.
  task automatic pulse_new();
    @(negedge clock);
    incoming_packet_new = 1'b1;
    @(negedge clock);
    incoming_packet_new = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if ({busy, pk_valid, peer_ack, bad_packet, dropped_packet} !== 5'b0 || their_pk !== 256'd0 || incoming_packet_read_index !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b pk_valid=%b ack=%b bad=%b drop=%b idx=%0d pk=%h, expected all zero",
               busy, pk_valid, peer_ack, bad_packet, dropped_packet, incoming_packet_read_index, their_pk);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_bad_header();
    load_pkt(16'h1234, 16'h0000);
    pulse_new();
    @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || bad_packet !== 1'b0 || incoming_packet_read_index !== 5'd1) begin
      miscompares++;
      $display("FAIL bad_hdr_wait: busy=%b bad=%b idx=%0d, expected 1 0 1", busy, bad_packet, incoming_packet_read_index);
    end
    @(negedge clock);
    vectors++;
    if (bad_packet !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_hdr_pulse: bad=%b busy=%b, expected 1 0", bad_packet, busy);
    end
    @(negedge clock);
    vectors++;
    if (bad_packet !== 1'b0 || pk_valid !== 1'b0 || their_pk !== 256'd0 || peer_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_hdr_after: bad=%b pk_valid=%b ack=%b pk=%h, expected 0 0 0 0", bad_packet, pk_valid, peer_ack, their_pk);
    end
  endtask

  task automatic test_nominal();
    load_pkt(16'h5555, 16'h0000);
    pulse_new();
    repeat (18) @(negedge clock);
    vectors++;
    if (pk_valid !== 1'b0 || their_pk !== 256'd0 || busy !== 1'b1 || incoming_packet_read_index !== 5'd16) begin
      miscompares++;
      $display("FAIL nominal_edge18: pk_valid=%b busy=%b idx=%0d pk=%h, expected 0 1 16 0", pk_valid, busy, incoming_packet_read_index, their_pk);
    end
    @(negedge clock);
    vectors++;
    if (their_pk !== exp_key(16'h0000) || their_pk[255:240] !== 16'h0001 || their_pk[15:0] !== 16'h0010) begin
      miscompares++;
      $display("FAIL nominal_key: got %h, expected %h", their_pk, exp_key(16'h0000));
    end
    vectors++;
    if (peer_ack !== 1'b0 || pk_valid !== EXP_FIRST || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_flags: ack=%b pk_valid=%b busy=%b, expected 0 %b 0", peer_ack, pk_valid, EXP_FIRST, busy);
    end
  endtask

  task automatic test_ack();
    load_pkt(16'hAAAA, 16'h0000);
    pulse_new();
    repeat (19) @(negedge clock);
    vectors++;
    if (peer_ack !== 1'b1 || pk_valid !== 1'b1 || their_pk !== exp_key(16'h0000)) begin
      miscompares++;
      $display("FAIL ack_pkt: ack=%b pk_valid=%b pk=%h, expected 1 1 %h", peer_ack, pk_valid, their_pk, exp_key(16'h0000));
    end
  endtask

  task automatic test_drop_mid();
    load_pkt(16'h5555, 16'h0200);
    pulse_new();
    repeat (4) @(negedge clock);
    incoming_packet_new = 1'b1;
    @(negedge clock);
    incoming_packet_new = 1'b0;
    vectors++;
    if (dropped_packet !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_pulse: drop=%b busy=%b, expected 1 1", dropped_packet, busy);
    end
    @(negedge clock);
    vectors++;
    if (dropped_packet !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_width: drop=%b, expected 0", dropped_packet);
    end
    repeat (13) @(negedge clock);
    vectors++;
    if (their_pk !== exp_key(16'h0200) || peer_ack !== 1'b0 || pk_valid !== EXP_DIFF) begin
      miscompares++;
      $display("FAIL drop_commit: pk=%h ack=%b pk_valid=%b, expected %h 0 %b", their_pk, peer_ack, pk_valid, exp_key(16'h0200), EXP_DIFF);
    end
  endtask

  task automatic test_back_to_back();
    load_pkt(16'hAAAA, 16'h0200);
    pulse_new();
    repeat (18) @(negedge clock);
    incoming_packet_new = 1'b1;
    @(negedge clock);
    incoming_packet_new = 1'b0;
    vectors++;
    if (dropped_packet !== 1'b1 || busy !== 1'b0 || their_pk !== exp_key(16'h0200) || peer_ack !== 1'b1 || pk_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_commit: drop=%b busy=%b ack=%b pk_valid=%b pk=%h, expected 1 0 1 1 %h",
               dropped_packet, busy, peer_ack, pk_valid, their_pk, exp_key(16'h0200));
    end
    @(negedge clock);
    vectors++;
    if (dropped_packet !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_after: drop=%b busy=%b, expected 0 0", dropped_packet, busy);
    end
  endtask

  task automatic test_reset_mid();
    load_pkt(16'h5555, 16'h0300);
    pulse_new();
    repeat (9) @(negedge clock);
    reset = 1'b1;
    incoming_packet_new = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    incoming_packet_new = 1'b0;
    vectors++;
    if (busy !== 1'b0 || pk_valid !== 1'b0 || peer_ack !== 1'b0 || their_pk !== 256'd0 || incoming_packet_read_index !== 5'd0 || dropped_packet !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b pk_valid=%b ack=%b drop=%b idx=%0d pk=%h, expected all zero",
               busy, pk_valid, peer_ack, dropped_packet, incoming_packet_read_index, their_pk);
    end
    pulse_new();
    repeat (19) @(negedge clock);
    vectors++;
    if (their_pk !== exp_key(16'h0300) || pk_valid !== EXP_FIRST || peer_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_reparse: pk=%h pk_valid=%b ack=%b, expected %h %b 0", their_pk, pk_valid, peer_ack, exp_key(16'h0300), EXP_FIRST);
    end
  endtask

  task automatic test_stable();
    load_pkt(16'h5555, 16'h0300);
    pulse_new();
    repeat (19) @(negedge clock);
    vectors++;
    if (pk_valid !== 1'b1 || their_pk !== exp_key(16'h0300)) begin
      miscompares++;
      $display("FAIL stable_same: pk_valid=%b pk=%h, expected 1 %h", pk_valid, their_pk, exp_key(16'h0300));
    end
    load_pkt(16'h5555, 16'h0400);
    pulse_new();
    repeat (19) @(negedge clock);
    vectors++;
    if (pk_valid !== EXP_DIFF || their_pk !== exp_key(16'h0400)) begin
      miscompares++;
      $display("FAIL stable_change: pk_valid=%b pk=%h, expected %b %h", pk_valid, their_pk, EXP_DIFF, exp_key(16'h0400));
    end
  endtask

  initial begin
    reset = 1'b1;
    incoming_packet_new = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    test_reset();
    test_bad_header();
    test_nominal();
    test_ack();
    test_drop_mid();
    test_back_to_back();
    test_reset_mid();
    test_stable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/packet_receiver_fsm.md
PACKET_RECEIVER_FSM -- requirements
Module: packet_receiver_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning packet word width in bits.
REQ-002 SHALL have parameter PUBLIC_KEY_SIZE, default 256, meaning peer public key width; must be a multiple of WIDTH.
REQ-003 SHALL have parameter LOGSIZE, default 5, meaning packet buffer address width; 2**LOGSIZE >= 1 + PUBLIC_KEY_SIZE/WIDTH.
REQ-004 SHALL have port clock, input, 1 bit, meaning the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-006 SHALL have port incoming_packet_new, input, 1 bit, meaning a one-cycle pulse when a complete packet is in the buffer.
REQ-007 SHALL have port incoming_packet_read_index, output, LOGSIZE bits, meaning the buffer read address, registered.
REQ-008 SHALL have port incoming_packet_read_data, input, WIDTH bits, meaning buffer data; valid one cycle after the index is registered.
REQ-009 SHALL have port their_pk, output, PUBLIC_KEY_SIZE bits, meaning the last accepted peer public key.
REQ-010 SHALL have port pk_valid, output, 1 bit, meaning their_pk holds an accepted key; level signal.
REQ-011 SHALL have port peer_ack, output, 1 bit, meaning the header of the last accepted packet was ACK (16'hAAAA).
REQ-012 SHALL have port bad_packet, output, 1 bit, meaning a one-cycle pulse on header rejection.
REQ-013 SHALL have port dropped_packet, output, 1 bit, meaning a one-cycle pulse when incoming_packet_new arrives while busy.
REQ-014 SHALL have port busy, output, 1 bit, meaning high while in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, HDR_WAIT, HDR_CHECK, KEY_READ and COMMIT.
REQ-016 SHALL, in IDLE on incoming_packet_new=1, register read_index=0 and go to HDR_WAIT.
REQ-017 SHALL, in HDR_WAIT, register read_index=1 and go to HDR_CHECK.
REQ-018 SHALL, in HDR_CHECK, accept header 16'h5555 (NO_ACK) or 16'hAAAA (ACK): latch the ACK flag into staging, advance read_index, and go to KEY_READ.
REQ-019 SHALL, in HDR_CHECK on any other header, pulse bad_packet, return to IDLE, and leave their_pk, pk_valid and peer_ack unchanged.
REQ-020 SHALL store buffer word k (k=1..N, N=PUBLIC_KEY_SIZE/WIDTH) into staging bits [PUBLIC_KEY_SIZE-1-(k-1)*WIDTH -: WIDTH], MSB word first.
REQ-021 SHALL stop advancing read_index after index N and, once word N is stored, go to COMMIT.
REQ-022 SHALL, in COMMIT, copy staging into their_pk and peer_ack, set pk_valid=1 (subject to REQ-029), and return to IDLE; their_pk SHALL never show a partial key.
REQ-023 SHALL, with defaults, update their_pk/pk_valid on the edge 19 cycles after the edge sampling incoming_packet_new.
REQ-024 SHALL ignore incoming_packet_new when busy=1, pulse dropped_packet in that cycle, and not disturb the current parse.
REQ-025 SHALL, when incoming_packet_new=1 in the same cycle COMMIT returns to IDLE, treat it as busy: drop it and pulse dropped_packet.
REQ-026 SHALL keep pk_valid high once set, until reset, and update their_pk on each later accepted packet.

Reset
REQ-027 SHALL, on reset=1 at any clock edge including mid-packet, enter IDLE and clear all of the following to 0: read_index, their_pk, staging, pk_valid, peer_ack, bad_packet, dropped_packet and busy.
REQ-028 SHALL give reset priority over incoming_packet_new in the same cycle.

Configuration
REQ-029 SHALL, with macro PK_STABLE_CHECK_EN defined, assert pk_valid only when two consecutive accepted packets carry identical keys; on a mismatch, pk_valid SHALL clear, their_pk SHALL take the new key, and the comparison SHALL restart.
REQ-030 SHALL, without PK_STABLE_CHECK_EN, assert pk_valid after the first accepted packet and omit the comparison logic.

Verification
REQ-031 SHALL cover: header 5555 plus words 0x0001..0x0010 -> their_pk[255:240]=0x0001, their_pk[15:0]=0x0010, peer_ack=0, pk_valid=1 on edge 19.
REQ-032 SHALL cover: header AAAA plus the same key -> peer_ack=1 and their_pk unchanged in value.
REQ-033 SHALL cover: header 1234 -> bad_packet pulses once in HDR_CHECK, pk_valid stays 0, and busy drops the next cycle.
REQ-034 SHALL cover: a second incoming_packet_new at cycle 5 of a parse -> dropped_packet=1 for one cycle, and the first key commits correctly.
REQ-035 SHALL cover: reset at cycle 10 of a parse -> next cycle busy=0, their_pk=0 and pk_valid=0, and a following packet parses normally.
REQ-036 SHALL cover, with PK_STABLE_CHECK_EN defined: key A, then A -> pk_valid=1 after the second packet; then key B -> pk_valid=0 and their_pk=B.
